// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ==========================================================================
// Module : axi_lite_pkg
// Brief  : AXI-Lite response codes and command-master FSM state encodings.
// Rev    : 1.0
// ==========================================================================
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_REQ  = 3'd1;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_REQ  = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;

endpackage
`default_nettype wire

// File: rtl/axi_lite_cmd_master_if.sv
`default_nettype none
// ==========================================================================
// Module : axi_lite_cmd_master_if
// Brief  : AXI-Lite read/write channel bundle with master and slave views.
// Rev    : 1.0
// ==========================================================================
interface axi_lite_cmd_master_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
   logic                    awvalid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awready;
   logic                    wvalid;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [STROBE_WIDTH-1:0] wstrb;
   logic                    wready;
   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;
   logic                    arvalid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arready;
   logic                    rvalid;
   logic                    rready;
   logic [1:0]              rresp;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_timeout.sv
`default_nettype none
// ==========================================================================
// Module : axi_lite_timeout
// Brief  : Watchdog counter; o_expire flags the cycle the count reaches the limit.
// Rev    : 1.0
// ==========================================================================
module axi_lite_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);
   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q lags by one, so LAST here is the cycle the count becomes the limit
   assign o_expire = i_enable && (count_q == LAST);
endmodule
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ==========================================================================
// Module : axi_lite_cmd_master
// Brief  : Single-outstanding command port to AXI-Lite master bridge.
// Macro  : AXI_LITE_CMD_MASTER_TIMEOUT_EN adds a per-transaction watchdog.
// Rev    : 1.0
// ==========================================================================
module axi_lite_cmd_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_cmd_stb,
   input  logic                     i_cmd_wr,
   input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
   input  logic [DATA_WIDTH-1:0]    i_cmd_data,
   input  logic [STROBE_WIDTH-1:0]  i_cmd_strb,
   output logic                     o_cmd_rdy,
   output logic                     o_rsp_stb,
   output logic [DATA_WIDTH-1:0]    o_rsp_data,
   output logic [1:0]               o_rsp_resp,
   output logic                     o_rsp_timeout,
   axi_lite_cmd_master_if.master    m_axi
);
   logic [2:0]              state_q,       state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,        addr_d;
   logic [DATA_WIDTH-1:0]   data_q,        data_d;
   logic [STROBE_WIDTH-1:0] strb_q,        strb_d;
   logic                    awvalid_q,     awvalid_d;
   logic                    wvalid_q,      wvalid_d;
   logic                    bready_q,      bready_d;
   logic                    arvalid_q,     arvalid_d;
   logic                    rready_q,      rready_d;
   logic                    rsp_stb_q,     rsp_stb_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q,    rsp_data_d;
   logic [1:0]              rsp_resp_q,    rsp_resp_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic                    w_expire;
   logic                    w_accept;
   logic                    w_busy;

   assign w_accept = (state_q == ST_IDLE) && i_cmd_stb;
   assign w_busy   = (state_q != ST_IDLE);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
   axi_lite_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_accept),
      .i_enable (w_busy),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      data_d        = data_q;
      strb_d        = strb_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_stb_d     = 1'b0;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               addr_d = i_cmd_addr;
               data_d = i_cmd_data;
               strb_d = i_cmd_strb;
               if (i_cmd_wr) begin
                  state_d   = ST_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR_REQ: begin
            // A low valid means that channel has already handshaken
            if (m_axi.awready) awvalid_d = 1'b0;
            if (m_axi.wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (m_axi.bvalid) begin
               state_d       = ST_IDLE;
               bready_d      = 1'b0;
               rsp_stb_d     = 1'b1;
               rsp_data_d    = '0;
               rsp_resp_d    = m_axi.bresp;
               rsp_timeout_d = 1'b0;
            end
         end
         ST_RD_REQ: begin
            if (m_axi.arready) begin
               state_d   = ST_RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (m_axi.rvalid) begin
               state_d       = ST_IDLE;
               rready_d      = 1'b0;
               rsp_stb_d     = 1'b1;
               rsp_data_d    = m_axi.rdata;
               rsp_resp_d    = m_axi.rresp;
               rsp_timeout_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A completing B/R handshake already returned to IDLE and wins over the watchdog
      if (w_expire && (state_d != ST_IDLE)) begin
         state_d       = ST_IDLE;
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_stb_d     = 1'b1;
         rsp_data_d    = '0;
         rsp_resp_d    = RESP_SLVERR;
         rsp_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         strb_q        <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_stb_q     <= 1'b0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= RESP_OKAY;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         strb_q        <= strb_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_stb_q     <= rsp_stb_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign o_cmd_rdy     = (state_q == ST_IDLE) && !rst;
   assign o_rsp_stb     = rsp_stb_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_resp    = rsp_resp_q;
   assign o_rsp_timeout = rsp_timeout_q;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = data_q;
   assign m_axi.wstrb   = strb_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.rready  = rready_q;
endmodule
`default_nettype wire
